// File: rtl/blend_pkg.sv
// ============================================================================
// Module      : blend_pkg
// Description : Pixel layout helpers shared by the layer compositor.
//               A pixel word is {R,G,B,A} with the 1-bit alpha in bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blend_pkg;

    localparam int unsigned DEF_COLOR_W = 4;
    localparam int unsigned A_OFS       = 0;
    localparam int unsigned B_OFS       = 1;

    function automatic int unsigned px_width(input int unsigned cw);
        return 3 * cw + 1;
    endfunction

    function automatic int unsigned g_ofs(input int unsigned cw);
        return cw + 1;
    endfunction

    function automatic int unsigned r_ofs(input int unsigned cw);
        return 2 * cw + 1;
    endfunction

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
        logic                   a;
    } rgba_t;

    function automatic rgba_t pack_rgba(input rgb_t c, input logic a);
        return '{r: c.r, g: c.g, b: c.b, a: a};
    endfunction

    // Opaque enabled pixel wins, otherwise the colour underneath shows through.
    function automatic rgb_t select_rgb(input rgba_t p, input logic en, input rgb_t under);
        return (en && p.a) ? '{r: p.r, g: p.g, b: p.b} : under;
    endfunction

endpackage

`default_nettype wire

// File: rtl/blend_stage.sv
// ============================================================================
// Module      : blend_stage
// Description : One registered priority-select stage of the compositor, with
//               SKEW delay registers aligning its layer pixel to the chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blend_stage
    import blend_pkg::*;
#(
    parameter int COLOR_W = 4,
    parameter int SKEW    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3*COLOR_W:0]     px_in,
    input  logic                   en_in,
    input  logic [3*COLOR_W-1:0]   acc_in,
    output logic [3*COLOR_W-1:0]   acc_out
);

    localparam int PX_W = int'(px_width(COLOR_W));

    logic [PX_W-1:0] px_slot;
    logic            en_slot;

    if (SKEW == 0) begin : g_no_skew
        assign px_slot = px_in;
        assign en_slot = en_in;
    end else begin : g_skew
        logic [PX_W-1:0] px_sr [SKEW];
        logic            en_sr [SKEW];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < SKEW; i++) begin
                    px_sr[i] <= '0;
                    en_sr[i] <= 1'b0;
                end
            end else begin
                px_sr[0] <= px_in;
                en_sr[0] <= en_in;
                for (int i = 1; i < SKEW; i++) begin
                    px_sr[i] <= px_sr[i-1];
                    en_sr[i] <= en_sr[i-1];
                end
            end
        end

        assign px_slot = px_sr[SKEW-1];
        assign en_slot = en_sr[SKEW-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out <= '0;
        end else begin
            acc_out <= (en_slot && px_slot[A_OFS]) ? px_slot[PX_W-1:B_OFS] : acc_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_blender.sv
// ============================================================================
// Module      : layer_blender
// Description : N-layer alpha-priority pixel compositor, NUM_LAYERS+2 cycle
//               latency. LAYER_BLENDER_COLLISION_EN adds player/scenery
//               per-frame collision detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_blender
    import blend_pkg::*;
#(
    parameter int                   NUM_LAYERS   = 4,
    parameter int                   COLOR_W      = 4,
    parameter logic [3*COLOR_W-1:0] BG_COLOR     = '0,
    parameter logic                 SYNC_IDLE    = 1'b1,
    parameter int                   PLAYER_LAYER = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic                                in_hsync,
    input  logic                                in_vsync,
    input  logic                                in_frame_start,
    input  logic [NUM_LAYERS*(3*COLOR_W+1)-1:0] layer_px,
    input  logic [NUM_LAYERS-1:0]               layer_en,
    output logic [COLOR_W-1:0]                  out_r,
    output logic [COLOR_W-1:0]                  out_g,
    output logic [COLOR_W-1:0]                  out_b,
    output logic                                out_hsync,
    output logic                                out_vsync,
    output logic                                out_valid
`ifdef LAYER_BLENDER_COLLISION_EN
    ,
    output logic                                collision,
    output logic                                collision_stb
`endif
);

    localparam int PX_W  = int'(px_width(COLOR_W));
    localparam int RGB_W = 3 * COLOR_W;

    // Asserts immediately, deasserts two clocks after rst falls.
    logic [1:0] rst_pipe;
    logic       rst_core;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst_core = rst_pipe[1];

    logic [NUM_LAYERS*PX_W-1:0] px_q;
    logic [NUM_LAYERS-1:0]      en_q;
    logic [NUM_LAYERS:0]        valid_d;
    logic [NUM_LAYERS:0]        hs_d;
    logic [NUM_LAYERS:0]        vs_d;

    always_ff @(posedge clk or posedge rst_core) begin
        if (rst_core) begin
            px_q    <= '0;
            en_q    <= '0;
            valid_d <= '0;
            hs_d    <= {(NUM_LAYERS+1){SYNC_IDLE}};
            vs_d    <= {(NUM_LAYERS+1){SYNC_IDLE}};
        end else begin
            px_q    <= layer_px;
            en_q    <= layer_en;
            valid_d <= {valid_d[NUM_LAYERS-1:0], in_valid};
            hs_d    <= {hs_d[NUM_LAYERS-1:0], in_hsync};
            vs_d    <= {vs_d[NUM_LAYERS-1:0], in_vsync};
        end
    end

    logic [RGB_W-1:0] acc_chain [NUM_LAYERS+1];

    assign acc_chain[0] = BG_COLOR;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_stage
        blend_stage #(
            .COLOR_W (COLOR_W),
            .SKEW    (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst_core),
            .px_in   (px_q[k*PX_W +: PX_W]),
            .en_in   (en_q[k]),
            .acc_in  (acc_chain[k]),
            .acc_out (acc_chain[k+1])
        );
    end

    always_ff @(posedge clk or posedge rst_core) begin
        if (rst_core) begin
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_valid <= 1'b0;
            out_hsync <= SYNC_IDLE;
            out_vsync <= SYNC_IDLE;
        end else begin
            out_valid <= valid_d[NUM_LAYERS];
            out_hsync <= hs_d[NUM_LAYERS];
            out_vsync <= vs_d[NUM_LAYERS];
            {out_r, out_g, out_b} <= valid_d[NUM_LAYERS] ? acc_chain[NUM_LAYERS] : '0;
        end
    end

`ifdef LAYER_BLENDER_COLLISION_EN
    logic                hit_in;
    logic                hit_acc;
    logic [NUM_LAYERS:0] hit_d;
    logic [NUM_LAYERS:0] fs_d;

    // Layer 0 is background and never counts as scenery.
    always_comb begin
        hit_in = 1'b0;
        for (int j = 1; j < NUM_LAYERS; j++) begin
            if (j != PLAYER_LAYER && layer_en[j] && layer_px[j*PX_W]) begin
                hit_in = 1'b1;
            end
        end
        hit_in = hit_in && in_valid && layer_en[PLAYER_LAYER] && layer_px[PLAYER_LAYER*PX_W];
    end

    // The frame_start pixel's own hit seeds the new frame, not the old one.
    always_ff @(posedge clk or posedge rst_core) begin
        if (rst_core) begin
            hit_d         <= '0;
            fs_d          <= '0;
            hit_acc       <= 1'b0;
            collision     <= 1'b0;
            collision_stb <= 1'b0;
        end else begin
            hit_d <= {hit_d[NUM_LAYERS-1:0], hit_in};
            fs_d  <= {fs_d[NUM_LAYERS-1:0], in_frame_start};
            if (fs_d[NUM_LAYERS]) begin
                collision     <= hit_acc;
                hit_acc       <= hit_d[NUM_LAYERS];
                collision_stb <= 1'b1;
            end else begin
                hit_acc       <= hit_acc | hit_d[NUM_LAYERS];
                collision_stb <= 1'b0;
            end
        end
    end
`else
    logic unused_frame_start;
    assign unused_frame_start = in_frame_start;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_blender.sv
// ============================================================================
// Module      : tb_layer_blender
// Description : Directed self-checking bench for layer_blender; collision
//               checks are active when LAYER_BLENDER_COLLISION_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_blender;

    localparam int NL  = 4;
    localparam int CW  = 4;
    localparam int PXW = 13;
    localparam int LAT = NL + 2;

    localparam logic [12:0] TCOL   = 13'h0AAA; // coloured but transparent
    localparam logic [12:0] WHITE  = 13'h1FFF;
    localparam logic [12:0] RED    = 13'h1E01;
    localparam logic [12:0] GREEN  = 13'h01E1;
    localparam logic [12:0] BLUE_P = 13'h001F;
    localparam logic [11:0] BG     = 12'h5A3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_hsync = 1'b1;
    logic              in_vsync = 1'b1;
    logic              in_frame_start = 1'b0;
    logic [NL*PXW-1:0] layer_px = '0;
    logic [NL-1:0]     layer_en = '0;
    logic [CW-1:0]     out_r, out_g, out_b;
    logic              out_hsync, out_vsync, out_valid;
`ifdef LAYER_BLENDER_COLLISION_EN
    logic              collision, collision_stb;
`endif

    layer_blender #(
        .NUM_LAYERS   (NL),
        .COLOR_W      (CW),
        .BG_COLOR     (BG),
        .SYNC_IDLE    (1'b1),
        .PLAYER_LAYER (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_hsync       (in_hsync),
        .in_vsync       (in_vsync),
        .in_frame_start (in_frame_start),
        .layer_px       (layer_px),
        .layer_en       (layer_en),
        .out_r          (out_r),
        .out_g          (out_g),
        .out_b          (out_b),
        .out_hsync      (out_hsync),
        .out_vsync      (out_vsync),
        .out_valid      (out_valid)
`ifdef LAYER_BLENDER_COLLISION_EN
        ,
        .collision      (collision),
        .collision_stb  (collision_stb)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        v;
        logic        hs;
        logic        vs;
        logic        col;
        logic        stb;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_now(input logic [11:0] e_rgb, input logic e_v, input logic e_hs,
                             input logic e_vs, input logic e_col, input logic e_stb);
        check("rgb", {20'h0, out_r, out_g, out_b}, {20'h0, e_rgb});
        check("valid", {31'h0, out_valid}, {31'h0, e_v});
        check("hsync", {31'h0, out_hsync}, {31'h0, e_hs});
        check("vsync", {31'h0, out_vsync}, {31'h0, e_vs});
`ifdef LAYER_BLENDER_COLLISION_EN
        check("collision", {31'h0, collision}, {31'h0, e_col});
        check("collision_stb", {31'h0, collision_stb}, {31'h0, e_stb});
`else
        if (e_col || e_stb) n_vec = n_vec + 0;
`endif
    endtask

    // Drive one pixel slot and check the slot issued LAT cycles earlier.
    task automatic step(input logic [12:0] l3, input logic [12:0] l2, input logic [12:0] l1,
                        input logic [12:0] l0, input logic [3:0] en, input logic v,
                        input logic hs, input logic vs, input logic fs,
                        input logic [11:0] e_rgb, input logic e_col, input logic e_stb);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == LAT) begin
            e = exp_q.pop_front();
            check_now(e.rgb, e.v, e.hs, e.vs, e.col, e.stb);
        end
        layer_px       = {l3, l2, l1, l0};
        layer_en       = en;
        in_valid       = v;
        in_hsync       = hs;
        in_vsync       = vs;
        in_frame_start = fs;
        e.rgb = e_rgb;
        e.v   = v;
        e.hs  = hs;
        e.vs  = vs;
        e.col = e_col;
        e.stb = e_stb;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic e_col);
        for (int i = 0; i < n; i++) begin
            step(13'h0, 13'h0, 13'h0, 13'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, e_col, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_now(12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        idle(8, 1'b0);

        // All layers transparent: background colour
        step(TCOL, TCOL, TCOL, TCOL, 4'hF, 1, 1, 1, 0, BG, 0, 0);
        step(TCOL, TCOL, TCOL, TCOL, 4'hF, 1, 1, 1, 0, BG, 0, 0);

        // Priority and per-pixel enable
        step(TCOL,  RED, TCOL, WHITE, 4'hF, 1, 1, 1, 0, 12'hF00, 0, 0);
        step(TCOL,  RED, TCOL, WHITE, 4'hB, 1, 1, 1, 0, 12'hFFF, 0, 0);
        step(TCOL,  RED, TCOL, WHITE, 4'hF, 1, 1, 1, 0, 12'hF00, 0, 0);
        step(TCOL,  RED, TCOL, WHITE, 4'h0, 1, 1, 1, 0, BG,      0, 0);
        step(GREEN, RED, TCOL, WHITE, 4'hF, 1, 1, 1, 0, 12'h0F0, 0, 0);
        step(GREEN, RED, TCOL, WHITE, 4'h7, 1, 1, 1, 0, 12'hF00, 0, 0);

        // Blanking with sync patterns
        step(GREEN, RED, TCOL, WHITE, 4'hF, 0, 0, 1, 0, 12'h000, 0, 0);
        step(GREEN, RED, TCOL, WHITE, 4'hF, 0, 1, 0, 0, 12'h000, 0, 0);
        step(GREEN, RED, TCOL, WHITE, 4'hF, 0, 0, 0, 0, 12'h000, 0, 0);
        step(GREEN, RED, TCOL, WHITE, 4'hF, 1, 1, 1, 0, 12'h0F0, 0, 0);

        // Collision frames
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 0, 1);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 0, 12'hFFF, 0, 0);
        step(TCOL,  RED,  BLUE_P, WHITE, 4'hF, 1, 1, 1, 0, 12'hF00, 0, 0);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 0, 12'hFFF, 0, 0);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 1, 1);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 0, 12'hFFF, 1, 0);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 0, 1);
        // Player over background only, disabled scenery, blanked overlap: no hit
        step(TCOL,  TCOL, BLUE_P, WHITE, 4'hF, 1, 1, 1, 0, 12'h00F, 0, 0);
        step(TCOL,  RED,  BLUE_P, WHITE, 4'hB, 1, 1, 1, 0, 12'h00F, 0, 0);
        step(GREEN, TCOL, BLUE_P, WHITE, 4'hF, 0, 1, 1, 0, 12'h000, 0, 0);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 0, 1);
        // Back-to-back frame_start: second reports only the first pixel's hit
        step(TCOL,  RED,  BLUE_P, WHITE, 4'hF, 1, 1, 1, 1, 12'hF00, 0, 1);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 1, 1);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 0, 12'hFFF, 1, 0);
        step(TCOL,  TCOL, TCOL,   WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 0, 1);

        // Overlap in flight, then asynchronous reset mid-cycle
        for (int i = 0; i < 8; i++) begin
            step(GREEN, TCOL, BLUE_P, WHITE, 4'hF, 1, 0, 1, 0, 12'h0F0, 0, 0);
        end
        #2 rst = 1'b1;
        #1 check_now(12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(8, 1'b0);
        step(TCOL, TCOL, TCOL, WHITE, 4'hF, 1, 1, 1, 1, 12'hFFF, 0, 1);
        idle(LAT, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
